// File: rtl/signature_analyzer_if.sv
// ---------------------------------------------------------------------------
// signature_analyzer_if
//   Handshake/observation bundle between a stimulus source and the signature
//   analyzer. The master side drives the run control and observation words;
//   the slave side (the analyzer) returns its counter, signature and status.
//
//   start        master->slave  1-cycle request to begin a run
//   abort        master->slave  cancel a run, return to IDLE
//   mode         master->slave  0 = add compression, 1 = XOR compression
//   data_valid   master->slave  data_in carries a sample this cycle
//   data_in      master->slave  DATA_W-bit observation word
//   golden       master->slave  expected signature, compared in DONE
//   sample_count slave->master  samples accepted in current run
//   signature    slave->master  accumulator register
//   busy         slave->master  run in progress
//   done         slave->master  run complete, signature frozen
//   pass         slave->master  done and signature equals golden
// ---------------------------------------------------------------------------
interface signature_analyzer_if #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned SIG_W   = 16,
    parameter int unsigned COUNT_W = 8
) ();
    logic               start;
    logic               abort;
    logic               mode;
    logic               data_valid;
    logic [DATA_W-1:0]  data_in;
    logic [SIG_W-1:0]   golden;
    logic [COUNT_W-1:0] sample_count;
    logic [SIG_W-1:0]   signature;
    logic               busy;
    logic               done;
    logic               pass;

    modport master (
        output start, abort, mode, data_valid, data_in, golden,
        input  sample_count, signature, busy, done, pass
    );

    modport slave (
        input  start, abort, mode, data_valid, data_in, golden,
        output sample_count, signature, busy, done, pass
    );
endinterface

// File: rtl/signature_analyzer.sv
// ---------------------------------------------------------------------------
// signature_analyzer
//   Compresses a stream of DATA_W-bit observation words into a SIG_W-bit
//   signature with a rotate-and-accumulate register. A run starts on start,
//   accepts N_SAMPLES valid words, then freezes in DONE where the signature
//   is compared against golden.
//
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    signature_analyzer_if slave port (control, data, status)
// ---------------------------------------------------------------------------
module signature_analyzer #(
    parameter int unsigned      DATA_W    = 8,
    parameter int unsigned      SIG_W     = 16,
    parameter int unsigned      COUNT_W   = 8,
    parameter int unsigned      N_SAMPLES = 255,
    parameter logic [SIG_W-1:0] SEED      = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    signature_analyzer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(N_SAMPLES);

    state_t             state_q, state_d;
    logic [SIG_W-1:0]   signature_q, signature_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               mode_q, mode_d;

    logic [DATA_W-1:0]  comp_s;
    logic [SIG_W-1:0]   signature_step;
    logic [COUNT_W-1:0] count_inc;

    // Compression step: combine the low DATA_W bits with the sample, then
    // rotate the whole register left by one so the old MSB lands in bit 0.
    always_comb begin
        comp_s = '0;
        if (mode_q) begin
            comp_s = signature_q[DATA_W-1:0] ^ bus.data_in;
        end else begin
            comp_s = signature_q[DATA_W-1:0] + bus.data_in;
        end
        signature_step = {signature_q[SIG_W-2:DATA_W], comp_s, signature_q[SIG_W-1]};
        count_inc      = count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            signature_q <= SEED;
            count_q     <= '0;
            mode_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            signature_q <= signature_d;
            count_q     <= count_d;
            mode_q      <= mode_d;
        end
    end

    // Abort has priority over start in every state; start is ignored in RUN.
    always_comb begin
        state_d     = state_q;
        signature_d = signature_q;
        count_d     = count_q;
        mode_d      = mode_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (bus.start) begin
                    state_d     = ST_RUN;
                    signature_d = SEED;
                    count_d     = '0;
                    mode_d      = bus.mode;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (bus.data_valid) begin
                    signature_d = signature_step;
                    count_d     = count_inc;
                    // Leave RUN on the edge that registers the last sample,
                    // so the counter saturates at N_SAMPLES.
                    if (count_inc == LAST_COUNT) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.sample_count = count_q;
    assign bus.signature    = signature_q;
    assign bus.busy         = (state_q == ST_RUN);
    assign bus.done         = (state_q == ST_DONE);
    assign bus.pass         = (state_q == ST_DONE) && (signature_q == bus.golden);

endmodule

// File: tb/tb_signature_analyzer.sv
module tb_signature_analyzer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic        mode;
    logic        data_valid;
    logic [7:0]  data_in;
    logic [15:0] golden;

    int n_cmp;
    int n_fail;

    // Four instances share one stimulus: N=2 seed 0, N=1 seed 0x00FF,
    // N=1 seed 0x8000, N=255 seed 0.
    signature_analyzer_if #(.DATA_W(8), .SIG_W(16), .COUNT_W(8)) bus_n2 ();
    signature_analyzer_if #(.DATA_W(8), .SIG_W(16), .COUNT_W(8)) bus_ff ();
    signature_analyzer_if #(.DATA_W(8), .SIG_W(16), .COUNT_W(8)) bus_80 ();
    signature_analyzer_if #(.DATA_W(8), .SIG_W(16), .COUNT_W(8)) bus_full ();

    assign bus_n2.start = start;     assign bus_n2.abort = abort;
    assign bus_n2.mode = mode;       assign bus_n2.data_valid = data_valid;
    assign bus_n2.data_in = data_in; assign bus_n2.golden = golden;
    assign bus_ff.start = start;     assign bus_ff.abort = abort;
    assign bus_ff.mode = mode;       assign bus_ff.data_valid = data_valid;
    assign bus_ff.data_in = data_in; assign bus_ff.golden = golden;
    assign bus_80.start = start;     assign bus_80.abort = abort;
    assign bus_80.mode = mode;       assign bus_80.data_valid = data_valid;
    assign bus_80.data_in = data_in; assign bus_80.golden = golden;
    assign bus_full.start = start;     assign bus_full.abort = abort;
    assign bus_full.mode = mode;       assign bus_full.data_valid = data_valid;
    assign bus_full.data_in = data_in; assign bus_full.golden = golden;

    signature_analyzer #(.DATA_W(8), .SIG_W(16), .COUNT_W(8), .N_SAMPLES(2), .SEED(16'h0000))
        u_n2 (.clk(clk), .reset(reset), .bus(bus_n2));
    signature_analyzer #(.DATA_W(8), .SIG_W(16), .COUNT_W(8), .N_SAMPLES(1), .SEED(16'h00FF))
        u_ff (.clk(clk), .reset(reset), .bus(bus_ff));
    signature_analyzer #(.DATA_W(8), .SIG_W(16), .COUNT_W(8), .N_SAMPLES(1), .SEED(16'h8000))
        u_80 (.clk(clk), .reset(reset), .bus(bus_80));
    signature_analyzer #(.DATA_W(8), .SIG_W(16), .COUNT_W(8), .N_SAMPLES(255), .SEED(16'h0000))
        u_full (.clk(clk), .reset(reset), .bus(bus_full));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference compression of data words 0..n-1 in add mode.
    function automatic logic [15:0] ref_add_count(input logic [15:0] seed, input int n);
        logic [15:0] sig;
        logic [7:0]  low;
        sig = seed;
        for (int k = 0; k < n; k++) begin
            low = sig[7:0] + 8'(k);
            sig = {sig[14:8], low, sig[15]};
        end
        return sig;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0; abort = 1'b0; mode = 1'b0; data_valid = 1'b0;
        data_in = '0; golden = '0;
        repeat (2) cyc();
        n_cmp++; if (bus_n2.signature !== 16'h0000) begin n_fail++; $display("FAIL reset_sig_n2 got %h want 0000", bus_n2.signature); end
        n_cmp++; if (bus_ff.signature !== 16'h00FF) begin n_fail++; $display("FAIL reset_sig_ff got %h want 00ff", bus_ff.signature); end
        n_cmp++; if (bus_80.signature !== 16'h8000) begin n_fail++; $display("FAIL reset_sig_80 got %h want 8000", bus_80.signature); end
        n_cmp++; if ({bus_n2.busy, bus_n2.done, bus_n2.pass, bus_n2.sample_count} !== 11'd0)
            begin n_fail++; $display("FAIL reset_status got b%b d%b p%b c%0d want all 0", bus_n2.busy, bus_n2.done, bus_n2.pass, bus_n2.sample_count); end
        reset = 1'b1;
        cyc();
    endtask

    task automatic run_two(input logic m, input logic [15:0] sig1, input logic [15:0] sig2, input string tag);
        go_idle();
        mode = m;
        start = 1'b1;
        cyc();
        start = 1'b0;
        n_cmp++; if (bus_n2.busy !== 1'b1 || bus_n2.sample_count !== 8'd0 || bus_n2.signature !== 16'h0000)
            begin n_fail++; $display("FAIL %s_start got busy=%b cnt=%0d sig=%h want 1/0/0000", tag, bus_n2.busy, bus_n2.sample_count, bus_n2.signature); end
        data_valid = 1'b1; data_in = 8'h05;
        cyc();
        n_cmp++; if (bus_n2.signature !== sig1 || bus_n2.sample_count !== 8'd1 || bus_n2.done !== 1'b0)
            begin n_fail++; $display("FAIL %s_s1 got sig=%h cnt=%0d done=%b want %h/1/0", tag, bus_n2.signature, bus_n2.sample_count, bus_n2.done, sig1); end
        data_in = 8'h03;
        cyc();
        data_valid = 1'b0;
        n_cmp++; if (bus_n2.signature !== sig2 || bus_n2.sample_count !== 8'd2)
            begin n_fail++; $display("FAIL %s_s2 got sig=%h cnt=%0d want %h/2", tag, bus_n2.signature, bus_n2.sample_count, sig2); end
        n_cmp++; if (bus_n2.done !== 1'b1 || bus_n2.busy !== 1'b0)
            begin n_fail++; $display("FAIL %s_done got done=%b busy=%b want 1/0", tag, bus_n2.done, bus_n2.busy); end
        golden = sig2; #1;
        n_cmp++; if (bus_n2.pass !== 1'b1) begin n_fail++; $display("FAIL %s_pass_hit got %b want 1", tag, bus_n2.pass); end
        golden = sig2 + 16'd1; #1;
        n_cmp++; if (bus_n2.pass !== 1'b0) begin n_fail++; $display("FAIL %s_pass_miss got %b want 0", tag, bus_n2.pass); end
    endtask

    task automatic test_add_mode();
        run_two(1'b0, 16'h000A, 16'h001A, "add");
    endtask

    task automatic test_xor_mode();
        run_two(1'b1, 16'h000A, 16'h0012, "xor");
    endtask

    task automatic test_wrap_carry();
        go_idle();
        mode = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        data_valid = 1'b1; data_in = 8'h01; cyc(); data_valid = 1'b0;
        n_cmp++; if (bus_ff.signature !== 16'h0000 || bus_ff.done !== 1'b1)
            begin n_fail++; $display("FAIL wrap_ff got sig=%h done=%b want 0000/1", bus_ff.signature, bus_ff.done); end
        start = 1'b1; cyc(); start = 1'b0;
        data_valid = 1'b1; data_in = 8'h00; cyc(); data_valid = 1'b0;
        n_cmp++; if (bus_80.signature !== 16'h0001 || bus_80.done !== 1'b1)
            begin n_fail++; $display("FAIL rot_msb got sig=%h done=%b want 0001/1", bus_80.signature, bus_80.done); end
    endtask

    task automatic test_full_run();
        int idx;
        int n;
        logic [15:0] exp_sig;
        logic [15:0] held;
        go_idle();
        mode = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        idx = 0;
        n = 0;
        while (bus_full.done !== 1'b1 && n < 400) begin
            data_valid = ((n % 4) != 3);
            data_in = 8'(idx);
            cyc();
            if (data_valid) idx++;
            n++;
        end
        data_valid = 1'b0;
        exp_sig = ref_add_count(16'h0000, 255);
        n_cmp++; if (bus_full.done !== 1'b1) begin n_fail++; $display("FAIL full_done_timeout got done=%b after %0d cycles want 1", bus_full.done, n); end
        n_cmp++; if (bus_full.sample_count !== 8'd255) begin n_fail++; $display("FAIL full_count got %0d want 255", bus_full.sample_count); end
        n_cmp++; if (bus_full.signature !== exp_sig) begin n_fail++; $display("FAIL full_sig got %h want %h", bus_full.signature, exp_sig); end
        held = bus_full.signature;
        data_valid = 1'b1; data_in = 8'hA5;
        repeat (3) cyc();
        data_valid = 1'b0;
        n_cmp++; if (bus_full.signature !== exp_sig || bus_full.sample_count !== 8'd255 || bus_full.done !== 1'b1)
            begin n_fail++; $display("FAIL full_frozen got sig=%h cnt=%0d done=%b want %h/255/1 (was %h)", bus_full.signature, bus_full.sample_count, bus_full.done, exp_sig, held); end
    endtask

    task automatic test_abort();
        logic [15:0] exp_sig;
        go_idle();
        mode = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            data_valid = 1'b1; data_in = 8'(i);
            cyc();
        end
        data_valid = 1'b0;
        abort = 1'b1; cyc(); abort = 1'b0;
        exp_sig = ref_add_count(16'h0000, 10);
        n_cmp++; if (bus_full.busy !== 1'b0 || bus_full.done !== 1'b0 || bus_full.sample_count !== 8'd10)
            begin n_fail++; $display("FAIL abort_state got busy=%b done=%b cnt=%0d want 0/0/10", bus_full.busy, bus_full.done, bus_full.sample_count); end
        data_valid = 1'b1; data_in = 8'h77;
        repeat (3) cyc();
        data_valid = 1'b0;
        n_cmp++; if (bus_full.signature !== exp_sig || bus_full.sample_count !== 8'd10)
            begin n_fail++; $display("FAIL abort_hold got sig=%h cnt=%0d want %h/10", bus_full.signature, bus_full.sample_count, exp_sig); end
        start = 1'b1; abort = 1'b1; cyc(); start = 1'b0; abort = 1'b0;
        n_cmp++; if (bus_full.busy !== 1'b0 || bus_full.sample_count !== 8'd10 || bus_full.signature !== exp_sig)
            begin n_fail++; $display("FAIL start_abort got busy=%b cnt=%0d sig=%h want 0/10/%h", bus_full.busy, bus_full.sample_count, bus_full.signature, exp_sig); end
    endtask

    task automatic test_async_reset();
        go_idle();
        mode = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        data_valid = 1'b1; data_in = 8'h05; cyc(); data_valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        n_cmp++; if (bus_n2.signature !== 16'h0000 || bus_n2.busy !== 1'b0 || bus_n2.sample_count !== 8'd0)
            begin n_fail++; $display("FAIL async_rst got sig=%h busy=%b cnt=%0d want 0000/0/0", bus_n2.signature, bus_n2.busy, bus_n2.sample_count); end
        n_cmp++; if (bus_80.signature !== 16'h8000) begin n_fail++; $display("FAIL async_rst_seed got %h want 8000", bus_80.signature); end
        #0 reset = 1'b1;
        cyc();
        run_two(1'b0, 16'h000A, 16'h001A, "post_rst");
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        test_reset();
        test_add_mode();
        test_xor_mode();
        test_wrap_carry();
        test_full_run();
        test_abort();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
